// File: rtl/math_adder_seq_pkg.sv
// Shared constants and types for the sequential chunked adder.
package math_adder_seq_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/math_adder_brent_kung_016.sv
// 16-bit combinational Brent-Kung adder: log-depth up-sweep of group
// generate/propagate, then a down-sweep to fill in the remaining prefixes.
module math_adder_brent_kung_016 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] pp;

    always_comb begin
        pp = a ^ b;
        g  = a & b;
        p  = pp;
        // Fold carry-in into bit 0 so g[i] becomes the carry out of bit i.
        g[0] = g[0] | (p[0] & cin);

        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 << d)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                    p[i] = p[i] & p[i - (1 << d)];
                end
            end
        end

        for (int d = 2; d >= 0; d--) begin
            for (int i = 0; i < 16; i++) begin
                if ((i >= (3 << d) - 1) && (((i + 1 - (1 << d)) % (2 << d)) == 0)) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                    p[i] = p[i] & p[i - (1 << d)];
                end
            end
        end

        sum  = pp ^ {g[14:0], cin};
        cout = g[15];
    end

endmodule

// File: rtl/math_adder_brent_kung_wide_seq.sv
// Wide add/subtract built from one shared 16-bit Brent-Kung adder, one chunk
// per cycle LSB first, with a valid/ready handshake on both sides.
module math_adder_brent_kung_wide_seq
    import math_adder_seq_pkg::*;
#(
    parameter int TOTAL_WIDTH = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TOTAL_WIDTH-1:0] i_a,
    input  logic [TOTAL_WIDTH-1:0] i_b,
    input  logic                   i_cin,
    input  logic                   i_sub,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [TOTAL_WIDTH-1:0] o_sum,
    output logic                   o_cout,
    output logic                   o_overflow,
    output logic                   o_busy
);

    localparam int NUM_CHUNKS = TOTAL_WIDTH / CHUNK_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if ((TOTAL_WIDTH % CHUNK_W) != 0 || TOTAL_WIDTH < CHUNK_W) begin : g_bad_width
        $error("TOTAL_WIDTH must be a non-zero multiple of 16");
    end

    seq_state_t state;
    seq_state_t state_nxt;

    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] reg_a;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] reg_b;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] sum_r;
    logic                               carry_r;
    logic                               cout_r;
    logic                               ovf_r;
    logic [CNT_W-1:0]                   cnt;
    logic [CHUNK_W-1:0]                 add_sum;
    logic                               add_cout;
    logic                               last;

    assign last = (cnt == LAST_CHUNK);

    math_adder_brent_kung_016 u_add (
        .a    (reg_a[cnt]),
        .b    (reg_b[cnt]),
        .cin  (carry_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = CALC;
            CALC:    if (last)    state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is folded entirely into the B inversion and carry seed at
    // accept time, so no mode bit needs to travel with the operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reg_a   <= '0;
            reg_b   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        reg_a   <= i_a;
                        reg_b   <= i_sub ? ~i_b : i_b;
                        carry_r <= i_cin ^ i_sub;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    sum_r[cnt] <= add_sum;
                    carry_r    <= add_cout;
                    if (last) begin
                        cout_r <= add_cout;
                        ovf_r  <= (reg_a[NUM_CHUNKS-1][CHUNK_W-1] == reg_b[NUM_CHUNKS-1][CHUNK_W-1]) &&
                                  (add_sum[CHUNK_W-1] != reg_a[NUM_CHUNKS-1][CHUNK_W-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_valid    = (state == DONE);
    assign o_busy     = (state != IDLE);
    assign o_sum      = sum_r;
    assign o_cout     = cout_r;
    assign o_overflow = ovf_r;

endmodule

// File: tb/tb_math_adder_brent_kung_wide_seq.sv
// Directed bench: a 64-bit instance plus a 16-bit single-chunk instance.
module tb_math_adder_brent_kung_wide_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid, i_cin, i_sub, i_ready;
    logic [63:0] i_a, i_b;
    logic        o_ready, o_valid, o_cout, o_overflow, o_busy;
    logic [63:0] o_sum;

    logic        n_valid, n_cin, n_sub, n_ready;
    logic [15:0] n_a, n_b;
    logic        n_o_ready, n_o_valid, n_o_cout, n_o_overflow, n_o_busy;
    logic [15:0] n_o_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 i_clk = ~i_clk;

    math_adder_brent_kung_wide_seq #(.TOTAL_WIDTH(64)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    math_adder_brent_kung_wide_seq #(.TOTAL_WIDTH(16)) u_dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(n_valid), .o_ready(n_o_ready),
        .i_a(n_a), .i_b(n_b), .i_cin(n_cin), .i_sub(n_sub),
        .o_valid(n_o_valid), .i_ready(n_ready), .o_sum(n_o_sum), .o_cout(n_o_cout),
        .o_overflow(n_o_overflow), .o_busy(n_o_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on the negedge after acceptance; counts edges until o_valid.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!o_valid && edges < 40) begin
            @(posedge i_clk);
            edges++;
            @(negedge i_clk);
        end
    endtask

    task automatic run_req(input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub, output int edges);
        i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("accept_busy", {63'd0, o_busy}, 64'd1);
        wait_result(edges);
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
        check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_valid = 1'b0; i_cin = 1'b0; i_sub = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0;
        n_valid = 1'b0; n_cin = 1'b0; n_sub = 1'b0; n_ready = 1'b0;
        n_a = '0; n_b = '0;
        repeat (2) @(negedge i_clk);

        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_busy",  {63'd0, o_busy},  64'd0);
        check("rst_sum",   o_sum,            64'd0);
        check("rst_cout",  {63'd0, o_cout},  64'd0);
        check("rst_ovf",   {63'd0, o_overflow}, 64'd0);
        check("rst16_ready", {63'd0, n_o_ready}, 64'd1);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Carry ripples through every chunk.
        run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check("carry_lat",  lat, 64'd4);
        check("carry_sum",  o_sum, 64'd0);
        check("carry_cout", {63'd0, o_cout}, 64'd1);
        check("carry_ovf",  {63'd0, o_overflow}, 64'd0);
        check("carry_rdy",  {63'd0, o_ready}, 64'd0);
        release_result("carry_rel");

        // 0 - 1 borrows out of the top.
        run_req(64'd0, 64'd1, 1'b0, 1'b1, lat);
        check("sub_sum",  o_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_cout", {63'd0, o_cout}, 64'd0);
        check("sub_ovf",  {63'd0, o_overflow}, 64'd0);
        release_result("sub_rel");

        // 5 - 3 - borrow 1 = 1, no borrow out.
        run_req(64'd5, 64'd3, 1'b1, 1'b1, lat);
        check("subb_sum",  o_sum, 64'd1);
        check("subb_cout", {63'd0, o_cout}, 64'd1);
        release_result("subb_rel");

        // Signed overflow at the top.
        run_req(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check("ovf_sum",  o_sum, 64'h8000_0000_0000_0000);
        check("ovf_flag", {63'd0, o_overflow}, 64'd1);
        check("ovf_cout", {63'd0, o_cout}, 64'd0);
        release_result("ovf_rel");

        // Backpressure: result held, new requests ignored while DONE.
        run_req(64'd1, 64'd2, 1'b0, 1'b0, lat);
        check("bp_sum0", o_sum, 64'd3);
        for (int k = 0; k < 10; k++) begin
            i_valid = k[0];
            i_a = 64'hDEAD_0000 + 64'(k);
            @(negedge i_clk);
            check("bp_hold_sum",   o_sum, 64'd3);
            check("bp_hold_ready", {63'd0, o_ready}, 64'd0);
            check("bp_hold_valid", {63'd0, o_valid}, 64'd1);
        end
        i_a = 64'd10; i_b = 64'd20; i_valid = 1'b1; i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("bp_idle_ready", {63'd0, o_ready}, 64'd1);
        check("bp_idle_valid", {63'd0, o_valid}, 64'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("bp_accept_busy", {63'd0, o_busy}, 64'd1);
        wait_result(lat);
        check("bp_lat", lat, 64'd4);
        check("bp_sum", o_sum, 64'd30);
        release_result("bp_rel");

        // Reset while the chunk counter is 2.
        i_a = 64'hAAAA_BBBB_CCCC_DDDD; i_b = 64'h1111_2222_3333_4444; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        check("mid_busy", {63'd0, o_busy}, 64'd1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_ready", {63'd0, o_ready}, 64'd1);
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        check("mid_rst_busy",  {63'd0, o_busy},  64'd0);
        check("mid_rst_sum",   o_sum, 64'd0);
        check("mid_rst_cout",  {63'd0, o_cout}, 64'd0);
        check("mid_rst_ovf",   {63'd0, o_overflow}, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        run_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, lat);
        check("post_rst_lat",  lat, 64'd4);
        check("post_rst_sum",  o_sum, 64'h2222_2222_2222_2211);
        check("post_rst_cout", {63'd0, o_cout}, 64'd0);
        check("post_rst_ovf",  {63'd0, o_overflow}, 64'd0);
        release_result("post_rst_rel");

        // Single-chunk instance.
        n_a = 16'h8000; n_b = 16'h8000; n_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        n_valid = 1'b0;
        lat = 0;
        while (!n_o_valid && lat < 40) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
        end
        check("w16_lat",  lat, 64'd1);
        check("w16_sum",  {48'd0, n_o_sum}, 64'd0);
        check("w16_cout", {63'd0, n_o_cout}, 64'd1);
        check("w16_ovf",  {63'd0, n_o_overflow}, 64'd1);
        n_ready = 1'b1;
        @(negedge i_clk);
        n_ready = 1'b0;
        check("w16_rel_ready", {63'd0, n_o_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
